// File: rtl/aux_mod_counter_if.sv
// aux_mod_counter_if: control and status bundle for the modulus counter.
interface aux_mod_counter_if #(
    parameter int unsigned CntBit = 8,
    parameter int unsigned PreBit = 4
);
    logic              en_i;
    logic              ld_i;
    logic [CntBit-1:0] val_i;
    logic              up_i;
    logic [PreBit-1:0] div_i;
    logic              clr_ovf_i;
    logic [CntBit-1:0] cnt_o;
    logic              tc_o;
    logic              ovf_o;
    modport master (
        output en_i, ld_i, val_i, up_i, div_i, clr_ovf_i,
        input  cnt_o, tc_o, ovf_o
    );
    modport slave (
        input  en_i, ld_i, val_i, up_i, div_i, clr_ovf_i,
        output cnt_o, tc_o, ovf_o
    );
endinterface

// File: rtl/aux_mod_counter.sv
// aux_mod_counter: loadable up/down modulus counter with prescaler, wrap/saturate,
// terminal-count pulse and sticky overflow.
module aux_mod_counter #(
    parameter int unsigned CntBit   = 8,
    parameter int unsigned PreBit   = 4,
    parameter int unsigned ModVal   = 2**CntBit-1,
    parameter bit          Saturate = 1'b0
) (
    input logic              clk,
    input logic              rst,
    aux_mod_counter_if.slave bus
);
    localparam logic [CntBit-1:0] Max = CntBit'(ModVal);
    logic [CntBit-1:0] cnt_q, cnt_d, nxt_cnt;
    logic [PreBit-1:0] pre_q, pre_d;
    logic              tc_q, tc_d, ovf_q, ovf_d;
    logic              step, at_top, at_bot, bnd;
    // at_top uses >= so a misconfigured out-of-range count still returns to range
    always_comb begin
        step    = bus.en_i && (pre_q >= bus.div_i);
        at_top  = cnt_q >= Max;
        at_bot  = cnt_q == '0;
        bnd     = !bus.ld_i && step && (bus.up_i ? at_top : at_bot);
        nxt_cnt = bus.up_i ? (at_top ? (Saturate ? Max : '0) : cnt_q + 1'b1)
                           : (at_bot ? (Saturate ? '0 : Max) : cnt_q - 1'b1);
        cnt_d   = bus.ld_i ? ((bus.val_i > Max) ? Max : bus.val_i) : step ? nxt_cnt : cnt_q;
        pre_d   = (bus.ld_i || step) ? '0 : bus.en_i ? pre_q + 1'b1 : pre_q;
        tc_d    = bnd;
        ovf_d   = bnd || (ovf_q && !bus.clr_ovf_i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pre_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end
    assign bus.cnt_o = cnt_q;
    assign bus.tc_o  = tc_q;
    assign bus.ovf_o = ovf_q;
endmodule

// File: tb/tb_aux_mod_counter.sv
// tb_aux_mod_counter: vector-table bench for wrap (w) and saturate (s) instances,
// CntBit=4, ModVal=11.
module tb_aux_mod_counter;
    typedef struct {
        bit       sel;
        bit       rst, en, ld;
        bit [3:0] val;
        bit       up;
        bit [3:0] div;
        bit       clr;
        bit [3:0] cnt;
        bit       tc, ovf;
    } vec_t;
    typedef struct {
        int       idx;
        bit       sel;
        bit [3:0] cnt;
        bit       tc, ovf;
    } exp_t;
    logic clk = 1'b0;
    logic rst_w = 1'b0, rst_s = 1'b0;
    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    aux_mod_counter_if #(.CntBit(4), .PreBit(4)) w ();
    aux_mod_counter_if #(.CntBit(4), .PreBit(4)) s ();
    aux_mod_counter #(.CntBit(4), .PreBit(4), .ModVal(11), .Saturate(1'b0)) u_w (
        .clk(clk), .rst(rst_w), .bus(w)
    );
    aux_mod_counter #(.CntBit(4), .PreBit(4), .ModVal(11), .Saturate(1'b1)) u_s (
        .clk(clk), .rst(rst_s), .bus(s)
    );
    function automatic void add(bit sel, bit r, bit e, bit l, int v, bit u, int d, bit c,
                                int ec, bit et, bit eo);
        vec_t x;
        x.sel = sel; x.rst = r; x.en = e; x.ld = l; x.val = 4'(v); x.up = u;
        x.div = 4'(d); x.clr = c; x.cnt = 4'(ec); x.tc = et; x.ovf = eo;
        tbl.push_back(x);
    endfunction
    task automatic apply(input vec_t x, input int idx);
        exp_t e, g;
        bit [3:0] a_cnt;
        bit a_tc, a_ovf;
        rst_w = !x.sel && x.rst; rst_s = x.sel && x.rst;
        w.en_i = !x.sel && x.en; w.ld_i = !x.sel && x.ld; w.clr_ovf_i = !x.sel && x.clr;
        s.en_i = x.sel && x.en;  s.ld_i = x.sel && x.ld;  s.clr_ovf_i = x.sel && x.clr;
        w.val_i = x.val; w.up_i = x.up; w.div_i = x.div;
        s.val_i = x.val; s.up_i = x.up; s.div_i = x.div;
        e.idx = idx; e.sel = x.sel; e.cnt = x.cnt; e.tc = x.tc; e.ovf = x.ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        a_cnt = g.sel ? s.cnt_o : w.cnt_o;
        a_tc  = g.sel ? s.tc_o  : w.tc_o;
        a_ovf = g.sel ? s.ovf_o : w.ovf_o;
        n_cmp++;
        if (a_cnt !== g.cnt || a_tc !== g.tc || a_ovf !== g.ovf) begin
            n_bad++;
            $display("FAIL vec%0d %s: cnt=%0d tc=%0d ovf=%0d, required cnt=%0d tc=%0d ovf=%0d",
                     g.idx, g.sel ? "sat" : "wrap", a_cnt, a_tc, a_ovf, g.cnt, g.tc, g.ovf);
        end
    endtask
    initial begin
        w.en_i = 0; w.ld_i = 0; w.val_i = 0; w.up_i = 0; w.div_i = 0; w.clr_ovf_i = 0;
        s.en_i = 0; s.ld_i = 0; s.val_i = 0; s.up_i = 0; s.div_i = 0; s.clr_ovf_i = 0;
        // wrap instance: reset, count up through the modulus
        add(0,1,0,0,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,0,0,0, 0,0,0);
        for (int i = 1; i <= 11; i++) add(0,0,1,0,0,1,0,0, i,0,0);
        add(0,0,1,0,0,1,0,0, 0,1,1);
        add(0,0,1,0,0,1,0,0, 1,0,1);
        // load and clamp
        add(0,0,1,1,9,1,0,0, 9,0,1);
        add(0,0,1,1,15,1,0,0, 11,0,1);
        add(0,0,1,1,11,1,0,0, 11,0,1);
        // overflow clear and clear/wrap race
        add(0,0,0,0,0,1,0,1, 11,0,0);
        add(0,0,1,0,0,1,0,1, 0,1,1);
        add(0,0,0,0,0,1,0,1, 0,0,0);
        // prescale div=2 with an enable gap, then div drop 2->0
        add(0,0,1,0,0,1,2,0, 0,0,0);
        add(0,0,1,0,0,1,2,0, 0,0,0);
        add(0,0,1,0,0,1,2,0, 1,0,0);
        add(0,0,1,0,0,1,2,0, 1,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0,0,0,1,2,0, 1,0,0);
        add(0,0,1,0,0,1,2,0, 1,0,0);
        add(0,0,1,0,0,1,2,0, 2,0,0);
        add(0,0,1,0,0,1,2,0, 2,0,0);
        add(0,0,1,0,0,1,2,0, 2,0,0);
        add(0,0,1,0,0,1,0,0, 3,0,0);
        add(0,0,1,0,0,1,0,0, 4,0,0);
        // down wrap
        add(0,0,1,1,1,0,0,0, 1,0,0);
        add(0,0,1,0,0,0,0,0, 0,0,0);
        add(0,0,1,0,0,0,0,0, 11,1,1);
        add(0,0,1,0,0,0,0,0, 10,0,1);
        // reset mid-operation at cnt=7, pre=1, ovf=1 with ld high
        add(0,0,1,1,6,1,0,0, 6,0,1);
        add(0,0,1,0,0,1,0,0, 7,0,1);
        add(0,0,1,0,0,1,2,0, 7,0,1);
        add(0,1,1,1,9,1,2,0, 0,0,0);
        add(0,0,1,0,0,1,2,0, 0,0,0);
        add(0,0,1,0,0,1,2,0, 0,0,0);
        add(0,0,1,0,0,1,2,0, 1,0,0);
        add(0,0,1,0,0,1,0,0, 2,0,0);
        // saturate instance: hold at top, then at bottom
        add(1,1,0,0,0,0,0,0, 0,0,0);
        add(1,0,1,1,10,1,0,0, 10,0,0);
        add(1,0,1,0,0,1,0,0, 11,0,0);
        add(1,0,1,0,0,1,0,0, 11,1,1);
        add(1,0,1,0,0,1,0,0, 11,1,1);
        add(1,0,0,0,0,1,0,0, 11,0,1);
        add(1,0,0,0,0,1,0,1, 11,0,0);
        add(1,0,1,1,1,0,0,0, 1,0,0);
        add(1,0,1,0,0,0,0,0, 0,0,0);
        add(1,0,1,0,0,0,0,0, 0,1,1);
        add(1,0,1,0,0,0,0,0, 0,1,1);
        add(1,0,0,0,0,0,0,0, 0,0,1);
        add(1,0,1,0,0,0,0,1, 0,1,1);
        add(1,0,0,0,0,0,0,1, 0,0,0);
        foreach (tbl[i]) apply(tbl[i], i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
